fp_multiplier_32bit: RTL
========================

FP_MULTIPLIER_32BIT -- requirements
Module: fp_multiplier_32bit

Interface
REQ-001 SHALL have one parameter: QNAN_VAL, default 32'h7FC0_0000, canonical quiet-NaN result pattern.
REQ-002 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port i_a, input, 32, IEEE-754 single operand A.
REQ-005 SHALL have port i_b, input, 32, IEEE-754 single operand B.
REQ-006 SHALL have port i_vld, input, 1, operands valid this cycle.
REQ-007 SHALL have port o_res, output, 32, product A*B, feeds adder_32bit i_a/i_b.
REQ-008 SHALL have port o_res_vld, output, 1, o_res valid; one pulse per accepted input.
REQ-009 SHALL have port overflow, output, 1, finite operands produced a result rounded to infinity.
REQ-010 SHALL have port underflow, output, 1, nonzero finite result flushed to zero.

Function
REQ-011 SHALL be fully pipelined, 3 stages: i_vld sampled at edge N gives o_res_vld=1 after edge N+3; one input accepted every cycle; no backpressure.
REQ-012 SHALL run stage 1 as: unpack, classify, sign = sa^sb, 10-bit signed exponent ea+eb-127, 24x24 hidden-bit mantissa product.
REQ-013 SHALL run stage 2 as: normalise; if product bit 47 is set, shift right 1 and increment exponent; form guard/round/sticky bits.
REQ-014 SHALL run stage 3 as: round; renormalise on mantissa carry-out; range check; pack; set flags.
REQ-015 SHALL treat subnormal inputs (exp=0, frac!=0) as signed zero (flush-to-zero).
REQ-016 SHALL map any NaN operand to QNAN_VAL, with overflow=0 and underflow=0.
REQ-017 SHALL map inf*0 (either order) to QNAN_VAL.
REQ-018 SHALL map inf*nonzero finite and inf*inf to infinity with sign sa^sb, overflow=0.
REQ-019 SHALL map zero*finite to zero with sign sa^sb, flags 0.
REQ-020 SHALL, when the final biased exponent is >= 255, output sign|7F800000 with overflow=1.
REQ-021 SHALL, when the final biased exponent is <= 0, output a signed zero with underflow=1.
REQ-022 SHALL register o_res, overflow and underflow only on valid beats; they hold their last value while o_res_vld=0.
REQ-023 SHALL assert flags in the same cycle as the o_res_vld of their result.

Reset
REQ-024 SHALL clear o_res, o_res_vld, overflow, underflow and all stage-valid bits to 0 while rst=1.
REQ-025 SHALL discard in-flight operations when rst is asserted mid-pipeline; no o_res_vld pulse appears for them after release.
REQ-026 SHALL sample the first post-reset i_vld on the first rising edge with rst=0.

Configuration
REQ-027 SHALL support macro FP_MUL_RNE_EN: when defined, stage 3 rounds to nearest, ties to even, using guard/round/sticky.
REQ-028 SHALL, when FP_MUL_RNE_EN is undefined, truncate (round toward zero); latency is unchanged.

Structure
REQ-029 SHALL take from shared package fp32_pkg: EXP_W=8, FRAC_W=23, BIAS=127, EXP_MAX=255, the QNAN/INF constants, and the class enum (ZERO, NORMAL, INF, NAN).
REQ-030 SHALL instantiate sub-module fp32_unpack (combinational; sign/exp/mant/class per operand) twice in stage 1; the same package is reused by adder_32bit.

Verification
REQ-031 SHALL show 40600000 * C0100000 (3.5*-2.25) -> C0FC0000 three cycles later, flags 0.
REQ-032 SHALL show 7FC00000 * 3F800000 -> 7FC00000, and 7F800000 * 00000000 -> 7FC00000.
REQ-033 SHALL show 7F000000 * 40000000 -> 7F800000 with overflow=1; 00800000 * 00800000 -> 00000000 with underflow=1.
REQ-034 SHALL show 3F800001 * 3FC00000 -> 3FC00002 with FP_MUL_RNE_EN defined, and 3FC00001 without it.
REQ-035 SHALL show 12 back-to-back i_vld beats (mix of the above) -> 12 consecutive o_res_vld pulses, in order, each correct.
REQ-036 SHALL show rst asserted with 2 ops in flight -> no o_res_vld after release; a fresh 3F800000 * 40000000 -> 40000000.

Source files
------------

// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared IEEE-754 single-precision field widths, constants and operand class
package fp32_pkg;

   localparam int EXP_W   = 8;
   localparam int FRAC_W  = 23;
   localparam int MANT_W  = FRAC_W + 1;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = 255;

   localparam logic [31:0] QNAN_BITS = 32'h7FC0_0000;
   localparam logic [31:0] INF_BITS  = 32'h7F80_0000;

   typedef enum logic [1:0] {
      ZERO   = 2'd0,
      NORMAL = 2'd1,
      INF    = 2'd2,
      NAN    = 2'd3
   } fp_class_e;

endpackage

// File: rtl/fp32_unpack.sv
// rtl/fp32_unpack.sv - combinational field split and classification of one fp32 operand
module fp32_unpack
   import fp32_pkg::*;
(
   input  logic [31:0]       op,
   output logic              sign,
   output logic [EXP_W-1:0]  exp,
   output logic [MANT_W-1:0] mant,
   output fp_class_e         cls
);

   localparam logic [EXP_W-1:0] EXP_ALL1 = EXP_W'(EXP_MAX);

   logic [FRAC_W-1:0] frac;

   always_comb begin
      sign = op[31];
      exp  = op[30:23];
      frac = op[22:0];
      mant = '0;
      cls  = NORMAL;
      if (exp == EXP_ALL1) begin
         cls = (frac != '0) ? NAN : INF;
      end else if (exp == '0) begin
         // subnormals are flushed: treated exactly like a signed zero
         cls = ZERO;
      end else begin
         mant = {1'b1, frac};
      end
   end

endmodule

// File: rtl/fp_multiplier_32bit.sv
// rtl/fp_multiplier_32bit.sv - 3-stage pipelined fp32 multiplier; FP_MUL_RNE_EN selects round-nearest-even
module fp_multiplier_32bit
   import fp32_pkg::*;
#(
   parameter logic [31:0] QNAN_VAL = QNAN_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_vld,
   output logic [31:0] o_res,
   output logic        o_res_vld,
   output logic        overflow,
   output logic        underflow
);

   localparam logic signed [9:0] EXP_TOP = 10'(EXP_MAX);

   logic        in_vld;
   logic [31:0] in_a, in_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_vld <= 1'b0;
         in_a   <= '0;
         in_b   <= '0;
      end else begin
         in_vld <= i_vld;
         if (i_vld) begin
            in_a <= i_a;
            in_b <= i_b;
         end
      end
   end

   logic              sa, sb;
   logic [EXP_W-1:0]  ea, eb;
   logic [MANT_W-1:0] ma, mb;
   fp_class_e         ca, cb;

   fp32_unpack u_unpack_a (.op(in_a), .sign(sa), .exp(ea), .mant(ma), .cls(ca));
   fp32_unpack u_unpack_b (.op(in_b), .sign(sb), .exp(eb), .mant(mb), .cls(cb));

   fp_class_e         s1_cls_n;
   logic signed [9:0] s1_exp_n;
   logic [47:0]       s1_prod_n;

   always_comb begin
      s1_cls_n = NORMAL;
      if (ca == NAN || cb == NAN) s1_cls_n = NAN;
      else if ((ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)) s1_cls_n = NAN;
      else if (ca == INF || cb == INF) s1_cls_n = INF;
      else if (ca == ZERO || cb == ZERO) s1_cls_n = ZERO;
   end

   assign s1_exp_n  = 10'({2'b00, ea}) + 10'({2'b00, eb}) - 10'(BIAS);
   assign s1_prod_n = 48'(ma) * 48'(mb);

   logic              s1_vld, s1_sign;
   fp_class_e         s1_cls;
   logic signed [9:0] s1_exp;
   logic [47:0]       s1_prod;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s1_sign <= 1'b0;
         s1_cls  <= ZERO;
         s1_exp  <= '0;
         s1_prod <= '0;
      end else begin
         s1_vld <= in_vld;
         if (in_vld) begin
            s1_sign <= sa ^ sb;
            s1_cls  <= s1_cls_n;
            s1_exp  <= s1_exp_n;
            s1_prod <= s1_prod_n;
         end
      end
   end

   // product of two 1.x mantissas lies in [1,4): at most one right shift
   logic [MANT_W-1:0] s2_mant_n;
   logic              s2_g_n, s2_r_n, s2_s_n;
   logic signed [9:0] s2_exp_n;

   always_comb begin
      if (s1_prod[47]) begin
         s2_mant_n = s1_prod[47:24];
         s2_g_n    = s1_prod[23];
         s2_r_n    = s1_prod[22];
         s2_s_n    = |s1_prod[21:0];
         s2_exp_n  = s1_exp + 10'sd1;
      end else begin
         s2_mant_n = s1_prod[46:23];
         s2_g_n    = s1_prod[22];
         s2_r_n    = s1_prod[21];
         s2_s_n    = |s1_prod[20:0];
         s2_exp_n  = s1_exp;
      end
   end

   logic              s2_vld, s2_sign, s2_g, s2_r, s2_s;
   fp_class_e         s2_cls;
   logic signed [9:0] s2_exp;
   logic [MANT_W-1:0] s2_mant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_vld  <= 1'b0;
         s2_sign <= 1'b0;
         s2_cls  <= ZERO;
         s2_exp  <= '0;
         s2_mant <= '0;
         s2_g    <= 1'b0;
         s2_r    <= 1'b0;
         s2_s    <= 1'b0;
      end else begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            s2_sign <= s1_sign;
            s2_cls  <= s1_cls;
            s2_exp  <= s2_exp_n;
            s2_mant <= s2_mant_n;
            s2_g    <= s2_g_n;
            s2_r    <= s2_r_n;
            s2_s    <= s2_s_n;
         end
      end
   end

   logic rnd_inc;
`ifdef FP_MUL_RNE_EN
   assign rnd_inc = s2_g & (s2_r | s2_s | s2_mant[0]);
`else
   logic unused_grs;
   assign rnd_inc    = 1'b0;
   assign unused_grs = s2_g ^ s2_r ^ s2_s;
`endif

   logic [MANT_W:0]   mant_rnd;
   logic signed [9:0] exp_rnd;
   logic [FRAC_W-1:0] frac_rnd;

   assign mant_rnd = {1'b0, s2_mant} + {{MANT_W{1'b0}}, rnd_inc};
   assign exp_rnd  = s2_exp + (mant_rnd[MANT_W] ? 10'sd1 : 10'sd0);
   assign frac_rnd = mant_rnd[MANT_W] ? mant_rnd[MANT_W-1:1] : mant_rnd[FRAC_W-1:0];

   logic [31:0] res_n;
   logic        ovf_n, unf_n;

   always_comb begin
      res_n = '0;
      ovf_n = 1'b0;
      unf_n = 1'b0;
      case (s2_cls)
         NAN:  res_n = QNAN_VAL;
         INF:  res_n = {s2_sign, INF_BITS[30:0]};
         ZERO: res_n = {s2_sign, 31'd0};
         default: begin
            if (exp_rnd >= EXP_TOP) begin
               res_n = {s2_sign, INF_BITS[30:0]};
               ovf_n = 1'b1;
            end else if (exp_rnd <= 10'sd0) begin
               res_n = {s2_sign, 31'd0};
               unf_n = 1'b1;
            end else begin
               res_n = {s2_sign, exp_rnd[7:0], frac_rnd};
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_res_vld <= 1'b0;
         o_res     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         o_res_vld <= s2_vld;
         if (s2_vld) begin
            o_res     <= res_n;
            overflow  <= ovf_n;
            underflow <= unf_n;
         end
      end
   end

endmodule
